// File: rtl/cpu_writeback_if.sv
// Result/writeback bus bundle for cpu_writeback.
// Carries the ALU and load-unit result handshakes, the issue-side pending-write
// marker, the busy scoreboard, the register-file write port and the forwarding
// lookup.  "slave" is the writeback unit's view, "master" the surrounding core's.
interface cpu_writeback_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [2:0]  alu_dest;
    logic [31:0] alu_data;

    logic        mem_valid;
    logic        mem_ready;
    logic [2:0]  mem_dest;
    logic [31:0] mem_data;

    logic        issue_valid;
    logic [2:0]  issue_dest;
    logic [7:0]  busy;

    logic        write_enable;
    logic [2:0]  write_dest;
    logic [31:0] write_data;

    logic [2:0]  fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    modport master (
        output alu_valid, alu_dest, alu_data,
        input  alu_ready,
        output mem_valid, mem_dest, mem_data,
        input  mem_ready,
        output issue_valid, issue_dest,
        input  busy,
        input  write_enable, write_dest, write_data,
        output fwd_addr,
        input  fwd_hit, fwd_data
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        output alu_ready,
        input  mem_valid, mem_dest, mem_data,
        output mem_ready,
        input  issue_valid, issue_dest,
        output busy,
        output write_enable, write_dest, write_data,
        input  fwd_addr,
        output fwd_hit, fwd_data
    );
endinterface

// File: rtl/cpu_writeback.sv
// cpu_writeback: merges ALU and load-unit results into one register-file
// write port through a small result FIFO, and keeps a per-register
// pending-write (busy) scoreboard.
// The load unit has fixed priority over the ALU.  One entry is popped on every
// edge the FIFO is non-empty; the popped entry drives the registered write port.
// Optional macro CPU_WB_BYPASS_EN compiles in a combinational forwarding lookup
// over the queued entries and the write output register; without it the
// forwarding outputs are tied to zero.
module cpu_writeback #(
    parameter int DEPTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    cpu_writeback_if.slave wb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    generate
        if (DEPTH != 2 && DEPTH != 4 && DEPTH != 8) begin : g_bad_depth
            $error("cpu_writeback: DEPTH must be 2, 4 or 8");
        end
    endgenerate

    typedef struct packed {
        logic [2:0]  dest;
        logic [31:0] data;
    } entry_t;

    // Storage is deliberately left out of reset; only entries between the
    // pointers are ever meaningful.
    entry_t            fifo_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              write_enable_q, write_enable_d;
    logic [2:0]        write_dest_q, write_dest_d;
    logic [31:0]       write_data_q, write_data_d;

    logic [7:0]        busy_q, busy_d;

    logic              space;
    logic              push_mem;
    logic              push_alu;
    logic              push;
    logic              pop;
    entry_t            push_entry;

    // The ALU yields whenever the load unit is presenting a result, so at most
    // one source is accepted per edge.
    assign space        = (count_q < CNT_W'(DEPTH));
    assign wb.mem_ready = space;
    assign wb.alu_ready = space & ~wb.mem_valid;

    assign push_mem = wb.mem_valid & space;
    assign push_alu = wb.alu_valid & space & ~wb.mem_valid;
    assign push     = push_mem | push_alu;
    // A freshly pushed entry is only visible to the pop side on the next edge,
    // because pop looks at the registered count.
    assign pop      = (count_q != '0);

    assign wb.write_enable = write_enable_q;
    assign wb.write_dest   = write_dest_q;
    assign wb.write_data   = write_data_q;
    assign wb.busy         = busy_q;

    // Select the accepted source (load unit first) for the tail slot.
    always_comb begin
        push_entry.dest = wb.alu_dest;
        push_entry.data = wb.alu_data;
        if (push_mem) begin
            push_entry.dest = wb.mem_dest;
            push_entry.data = wb.mem_data;
        end
    end

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Register-file write port: load the head on a pop, otherwise hold dest/data.
    always_comb begin
        write_enable_d = pop;
        write_dest_d   = write_dest_q;
        write_data_d   = write_data_q;
        if (pop) begin
            write_dest_d = fifo_q[rd_ptr_q].dest;
            write_data_d = fifo_q[rd_ptr_q].data;
        end
    end

    // Busy scoreboard: the write committing this edge clears its bit, a new
    // issue to the same register sets it again (set has the last word).
    always_comb begin
        busy_d = busy_q;
        if (write_enable_q) begin
            busy_d[write_dest_q] = 1'b0;
        end
        if (wb.issue_valid) begin
            busy_d[wb.issue_dest] = 1'b1;
        end
    end

    // Result storage write at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

    // Control, write port and scoreboard state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            write_enable_q <= 1'b0;
            write_dest_q   <= '0;
            write_data_q   <= '0;
            busy_q         <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            write_enable_q <= write_enable_d;
            write_dest_q   <= write_dest_d;
            write_data_q   <= write_data_d;
            busy_q         <= busy_d;
        end
    end

`ifdef CPU_WB_BYPASS_EN
    logic             fwd_hit_w;
    logic [31:0]      fwd_data_w;
    logic [PTR_W-1:0] fwd_idx;

    // Forwarding lookup: start from the output register, then walk the queue
    // oldest to newest so the youngest match overrides older ones.
    always_comb begin
        fwd_hit_w  = 1'b0;
        fwd_data_w = '0;
        fwd_idx    = rd_ptr_q;
        if (write_enable_q && (write_dest_q == wb.fwd_addr)) begin
            fwd_hit_w  = 1'b1;
            fwd_data_w = write_data_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (fifo_q[fwd_idx].dest == wb.fwd_addr)) begin
                fwd_hit_w  = 1'b1;
                fwd_data_w = fifo_q[fwd_idx].data;
            end
        end
    end

    assign wb.fwd_hit  = fwd_hit_w;
    assign wb.fwd_data = fwd_data_w;
`else
    logic unused_fwd_addr;

    assign unused_fwd_addr = ^wb.fwd_addr;
    assign wb.fwd_hit      = 1'b0;
    assign wb.fwd_data     = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_writeback.sv
// Self-checking bench for cpu_writeback (DEPTH=4).
// Accepted results are pushed to an expected-write queue at the accepting edge
// (using the bench's own priority model) and popped/compared whenever the DUT
// asserts write_enable.  Directed checks cover reset, latency, arbitration,
// busy scoreboard, mid-operation reset and forwarding (CPU_WB_BYPASS_EN aware).
module tb_cpu_writeback;
    logic clk;
    logic rst_n;

    cpu_writeback_if wb ();

    cpu_writeback #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb)
    );

    int checks   = 0;
    int failures = 0;

    logic [34:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bench model of acceptance: load unit wins, ALU only when load unit idle.
    always @(posedge clk) begin
        if (rst_n) begin
            if (wb.mem_valid && wb.mem_ready) begin
                exp_q.push_back({wb.mem_dest, wb.mem_data});
            end else if (wb.alu_valid && !wb.mem_valid && wb.alu_ready) begin
                exp_q.push_back({wb.alu_dest, wb.alu_data});
            end
        end
    end

    // Reset discards everything still queued.
    always @(negedge rst_n) begin
        exp_q.delete();
    end

    // Writeback monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [34:0] e;
        if (rst_n && wb.write_enable) begin
            chk("sb_has_entry", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wb_dest", {29'd0, wb.write_dest}, {29'd0, e[34:32]});
                chk("wb_data", wb.write_data, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        wb.alu_valid   = 1'b0;
        wb.alu_dest    = 3'd0;
        wb.alu_data    = 32'd0;
        wb.mem_valid   = 1'b0;
        wb.mem_dest    = 3'd0;
        wb.mem_data    = 32'd0;
        wb.issue_valid = 1'b0;
        wb.issue_dest  = 3'd0;
        wb.fwd_addr    = 3'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we",   {31'd0, wb.write_enable}, 32'd0);
        chk("rst_dest", {29'd0, wb.write_dest}, 32'd0);
        chk("rst_data", wb.write_data, 32'd0);
        chk("rst_busy", {24'd0, wb.busy}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_alu_ready", {31'd0, wb.alu_ready}, 32'd1);
        chk("post_rst_mem_ready", {31'd0, wb.mem_ready}, 32'd1);

        // Single ALU result: latency of two edges, then write_enable drops
        wb.alu_valid = 1'b1;
        wb.alu_dest  = 3'd3;
        wb.alu_data  = 32'hDEADBEEF;
        step();
        wb.alu_valid = 1'b0;
        chk("lat_we_e1", {31'd0, wb.write_enable}, 32'd0);
        step();
        chk("lat_we_e2",   {31'd0, wb.write_enable}, 32'd1);
        chk("lat_dest_e2", {29'd0, wb.write_dest}, 32'd3);
        chk("lat_data_e2", wb.write_data, 32'hDEADBEEF);
        step();
        chk("lat_we_e3",   {31'd0, wb.write_enable}, 32'd0);
        chk("hold_dest",   {29'd0, wb.write_dest}, 32'd3);
        chk("hold_data",   wb.write_data, 32'hDEADBEEF);

        // Arbitration: load unit first, ALU after
        wb.alu_valid = 1'b1;
        wb.alu_dest  = 3'd1;
        wb.alu_data  = 32'd1;
        wb.mem_valid = 1'b1;
        wb.mem_dest  = 3'd2;
        wb.mem_data  = 32'd2;
        #1;
        chk("arb_alu_ready0", {31'd0, wb.alu_ready}, 32'd0);
        chk("arb_mem_ready",  {31'd0, wb.mem_ready}, 32'd1);
        step();
        wb.mem_valid = 1'b0;
        #1;
        chk("arb_alu_ready1", {31'd0, wb.alu_ready}, 32'd1);
        step();
        wb.alu_valid = 1'b0;
        chk("arb_first_dest", {29'd0, wb.write_dest}, 32'd2);
        chk("arb_first_data", wb.write_data, 32'd2);
        step();
        chk("arb_second_dest", {29'd0, wb.write_dest}, 32'd1);
        chk("arb_second_data", wb.write_data, 32'd1);
        step();

        // Five back-to-back ALU results: ready never drops
        for (int i = 1; i <= 5; i++) begin
            wb.alu_valid = 1'b1;
            wb.alu_dest  = 3'(i);
            wb.alu_data  = 32'h11 * i;
            #1;
            chk("b2b_alu_ready", {31'd0, wb.alu_ready}, 32'd1);
            step();
        end
        wb.alu_valid = 1'b0;
        chk("b2b_last_we", {31'd0, wb.write_enable}, 32'd1);
        repeat (3) step();
        chk("b2b_drained", exp_q.size(), 32'd0);

        // Busy scoreboard: issue, then result, then clear after the write
        wb.issue_valid = 1'b1;
        wb.issue_dest  = 3'd5;
        step();
        wb.issue_valid = 1'b0;
        chk("busy_set", {31'd0, wb.busy[5]}, 32'd1);
        wb.alu_valid = 1'b1;
        wb.alu_dest  = 3'd5;
        wb.alu_data  = 32'h55;
        step();
        wb.alu_valid = 1'b0;
        chk("busy_held", {31'd0, wb.busy[5]}, 32'd1);
        step();
        chk("busy_write_we",   {31'd0, wb.write_enable}, 32'd1);
        chk("busy_during_wr",  {31'd0, wb.busy[5]}, 32'd1);
        step();
        chk("busy_cleared", {24'd0, wb.busy}, 32'd0);

        // Same-edge issue and write of register 5: set wins
        wb.alu_valid = 1'b1;
        wb.alu_dest  = 3'd5;
        wb.alu_data  = 32'h56;
        step();
        wb.alu_valid = 1'b0;
        step();
        chk("same_we",   {31'd0, wb.write_enable}, 32'd1);
        chk("same_dest", {29'd0, wb.write_dest}, 32'd5);
        wb.issue_valid = 1'b1;
        wb.issue_dest  = 3'd5;
        step();
        wb.issue_valid = 1'b0;
        chk("same_edge_set_wins", {31'd0, wb.busy[5]}, 32'd1);
        step();
        chk("same_edge_stays", {24'd0, wb.busy}, 32'h20);

        // Reset mid-operation with results in flight
        for (int i = 0; i < 2; i++) begin
            wb.alu_valid = 1'b1;
            wb.alu_dest  = 3'(i);
            wb.alu_data  = 32'h100 + i;
            step();
        end
        wb.alu_dest = 3'd2;
        wb.alu_data = 32'h102;
        chk("pre_rst_busy", {24'd0, wb.busy}, 32'h20);
        #3;
        rst_n        = 1'b0;
        wb.alu_valid = 1'b0;
        #1;
        chk("mid_rst_we",   {31'd0, wb.write_enable}, 32'd0);
        chk("mid_rst_busy", {24'd0, wb.busy}, 32'd0);
        chk("mid_rst_dest", {29'd0, wb.write_dest}, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rel_alu_ready", {31'd0, wb.alu_ready}, 32'd1);
        chk("rel_mem_ready", {31'd0, wb.mem_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_write", {31'd0, wb.write_enable}, 32'd0);
        end

        // Forwarding: two results for register 4 in flight
        wb.alu_valid = 1'b1;
        wb.alu_dest  = 3'd4;
        wb.alu_data  = 32'd10;
        step();
        wb.alu_data  = 32'd20;
        step();
        wb.alu_valid = 1'b0;
        wb.fwd_addr  = 3'd4;
        #1;
`ifdef CPU_WB_BYPASS_EN
        chk("fwd_hit_young",  {31'd0, wb.fwd_hit}, 32'd1);
        chk("fwd_data_young", wb.fwd_data, 32'd20);
        wb.fwd_addr = 3'd3;
        #1;
        chk("fwd_miss", {31'd0, wb.fwd_hit}, 32'd0);
        wb.fwd_addr = 3'd4;
        step();
        chk("fwd_hit_outreg",  {31'd0, wb.fwd_hit}, 32'd1);
        chk("fwd_data_outreg", wb.fwd_data, 32'd20);
`else
        chk("fwd_hit_off",  {31'd0, wb.fwd_hit}, 32'd0);
        chk("fwd_data_off", wb.fwd_data, 32'd0);
        step();
        chk("fwd_hit_off2", {31'd0, wb.fwd_hit}, 32'd0);
`endif
        repeat (3) step();
        chk("final_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
